systolic_tile_sched: RTL and testbench
======================================

// Module: systolic_tile_sched
// PURPOSE
//  Command-driven sequencer for the NxN systolic MAC array. Accepts one command
//  (K depth, tile count, output mode, read/write base addresses) and runs
//  start -> wait calc_done -> clear/drain -> wait dout_done once per tile.
//  Advances the memory bases per tile and translates the array's local raddr/waddr
//  into absolute memory addresses. Sits between the CPU-side command register
//  block and the array.
// PARAMETERS
//  N        8     array dimension; must match the array instance
//  TIMEOUT  1024  max cycles in CALC or DRAIN before error abort (>=4*N+256)
// PORTS
//  clk           in   1   clock
//  rst           in   1   synchronous reset, active-high
//  cmd_valid     in   1   command request
//  cmd_ready     out  1   high only in IDLE
//  cmd_k         in   8   K depth per tile (1..255)
//  cmd_tiles     in   8   number of tiles to run (1..255)
//  cmd_out_mode  in   1   0: row drain, 1: col drain
//  cmd_rbase     in   13  first operand read address
//  cmd_wbase     in   13  first result write address
//  busy          out  1   high from command accept until the done pulse
//  done          out  1   one-cycle completion pulse
//  err           out  1   sticky status, valid with done; cleared on next accept
//  sa_start      out  1   one-cycle start pulse to array
//  sa_clear      out  1   one-cycle drain pulse to array
//  sa_k_param    out  8   latched cmd_k
//  sa_out_mode   out  1   latched cmd_out_mode
//  sa_calc_done  in   1   array calc complete pulse
//  sa_dout_done  in   1   array drain complete pulse
//  sa_raddr      in   13  array local read address
//  sa_waddr      in   13  array local write address
//  mem_raddr     out  13  rbase_cur + sa_raddr, mod 2^13
//  mem_waddr     out  13  wbase_cur + sa_waddr, mod 2^13
// BEHAVIOUR
//  Reset: state IDLE; cmd_ready=1; busy, done, err, sa_start, sa_clear = 0;
//   sa_k_param=0; sa_out_mode=0; bases, tile and watchdog counters = 0.
//   Reset mid-operation aborts immediately with no done pulse.
//  Accept on cmd_valid && cmd_ready at edge T. Latch k, out_mode, bases;
//   tiles_left=cmd_tiles; err cleared. busy=1 from T+1.
//  Illegal command (cmd_k==0 or cmd_tiles==0): go directly to DONE. done=1 and
//   err=1 in T+1; no sa_start is issued.
//  FSM (registered, one state per cycle minimum):
//   IDLE  -> START on accept
//   START -> CALC: sa_start=1 for exactly this cycle; watchdog cleared
//   CALC  -> CLEAR on sa_calc_done; -> ERR if watchdog==TIMEOUT-1
//   CLEAR -> DRAIN: sa_clear=1 for exactly this cycle; watchdog cleared
//   DRAIN -> NEXT on sa_dout_done; -> ERR if watchdog==TIMEOUT-1
//   NEXT  rbase_cur+=k; wbase_cur+=N; tiles_left-=1;
//         -> DONE if tiles_left==1 (before decrement), else -> START
//   ERR   err=1 -> DONE
//   DONE  done=1 for one cycle, busy=0 in that cycle -> IDLE
//  Latency: accept edge T -> sa_start high in cycle T+1.
//   sa_dout_done of the last tile -> done 2 cycles later (NEXT, then DONE).
//  Simultaneous events:
//   - sa_calc_done / sa_dout_done in the same cycle as watchdog expiry: the done
//     input wins; no error.
//   - A done input arriving in any state other than CALC/DRAIN respectively is
//     ignored.
//   - cmd_valid while busy is ignored (cmd_ready=0).
//  Watchdog: 16-bit counter, increments each cycle in CALC/DRAIN, saturates.
//  Bases wrap modulo 2^13; no wrap detection.
//  sa_k_param and sa_out_mode are held constant for the whole command.
//  mem_raddr/mem_waddr are combinational from current bases and array addresses.
// TESTING
//  1 tile, k=4, rbase=0x100, wbase=0x200, array model -> one sa_start,
//    one sa_clear; mem_raddr 0x100..0x103; mem_waddr 0x200..0x207; done with err=0.
//  tiles=3, k=16, rbase=0, wbase=0x40 -> 3 start/clear pairs; second tile reads
//    from 16, third from 32; writes at 0x40, 0x48, 0x50; a single done pulse.
//  k=0 -> done and err high at T+1; sa_start never asserted; cmd_ready=1 at T+2.
//  Array model never returns calc_done, TIMEOUT=64 -> ERR after 64 cycles in
//    CALC; done with err=1. Next good command clears err.
//  sa_calc_done on the exact watchdog-expiry cycle -> CLEAR entered; err=0.
//  rst asserted during DRAIN of tile 2 of 3 -> all outputs at reset values
//    next cycle; no done pulse; rbase=0x1FF8 with k=16 wraps mem_raddr to 0x0008.

Source files
------------

// File: rtl/systolic_tile_sched.sv
// Per-tile sequencer for the NxN systolic MAC array: start -> calc -> drain, with
// per-tile base advance, watchdog abort, and local-to-absolute address translation.
module systolic_tile_sched #(
  parameter int N       = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_k,
  input  logic [7:0]  cmd_tiles,
  input  logic        cmd_out_mode,
  input  logic [12:0] cmd_rbase,
  input  logic [12:0] cmd_wbase,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        sa_start,
  output logic        sa_clear,
  output logic [7:0]  sa_k_param,
  output logic        sa_out_mode,
  input  logic        sa_calc_done,
  input  logic        sa_dout_done,
  input  logic [12:0] sa_raddr,
  input  logic [12:0] sa_waddr,
  output logic [12:0] mem_raddr,
  output logic [12:0] mem_waddr
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_CALC, S_CLEAR, S_DRAIN, S_NEXT, S_ERR, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] wdog;
  logic [7:0]  tiles_left;
  logic [12:0] rbase_cur, wbase_cur;
  logic        accept, illegal, wd_exp;

  assign accept  = cmd_valid && cmd_ready;
  assign illegal = (cmd_k == 8'd0) || (cmd_tiles == 8'd0);
  assign wd_exp  = (wdog == 16'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    sa_start  = 1'b0;
    sa_clear  = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (accept) state_nxt = illegal ? S_DONE : S_START;
      end
      S_START: begin
        busy      = 1'b1;
        sa_start  = 1'b1;
        state_nxt = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        // a completion arriving on the expiry cycle still counts as success
        if (sa_calc_done) state_nxt = S_CLEAR;
        else if (wd_exp)  state_nxt = S_ERR;
      end
      S_CLEAR: begin
        busy      = 1'b1;
        sa_clear  = 1'b1;
        state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (sa_dout_done) state_nxt = S_NEXT;
        else if (wd_exp)  state_nxt = S_ERR;
      end
      S_NEXT: begin
        busy      = 1'b1;
        state_nxt = (tiles_left == 8'd1) ? S_DONE : S_START;
      end
      S_ERR: begin
        busy      = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wdog        <= 16'd0;
      tiles_left  <= 8'd0;
      rbase_cur   <= 13'd0;
      wbase_cur   <= 13'd0;
      err         <= 1'b0;
      sa_k_param  <= 8'd0;
      sa_out_mode <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sa_k_param  <= cmd_k;
        sa_out_mode <= cmd_out_mode;
        rbase_cur   <= cmd_rbase;
        wbase_cur   <= cmd_wbase;
        tiles_left  <= cmd_tiles;
        err         <= illegal;
      end
      case (state)
        S_START, S_CLEAR: wdog <= 16'd0;
        S_CALC, S_DRAIN:  if (wdog != 16'hFFFF) wdog <= wdog + 16'd1;
        S_NEXT: begin
          rbase_cur  <= rbase_cur + {5'd0, sa_k_param};
          wbase_cur  <= wbase_cur + 13'(N);
          tiles_left <= tiles_left - 8'd1;
        end
        S_ERR:   err <= 1'b1;
        default: ;
      endcase
    end
  end

  assign mem_raddr = rbase_cur + sa_raddr;
  assign mem_waddr = wbase_cur + sa_waddr;

endmodule

// File: tb/tb_systolic_tile_sched.sv
// Randomized bench for systolic_tile_sched with a behavioural array model and
// per-command expectations derived from tile count, K and base arithmetic.
module tb_systolic_tile_sched;
  localparam int N  = 8;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_out_mode;
  logic [7:0]  cmd_k, cmd_tiles;
  logic [12:0] cmd_rbase, cmd_wbase;
  logic        busy, done, err, sa_start, sa_clear, sa_out_mode;
  logic [7:0]  sa_k_param;
  logic        sa_calc_done, sa_dout_done;
  logic [12:0] sa_raddr, sa_waddr, mem_raddr, mem_waddr;

  systolic_tile_sched #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_k(cmd_k), .cmd_tiles(cmd_tiles), .cmd_out_mode(cmd_out_mode),
    .cmd_rbase(cmd_rbase), .cmd_wbase(cmd_wbase), .busy(busy), .done(done),
    .err(err), .sa_start(sa_start), .sa_clear(sa_clear), .sa_k_param(sa_k_param),
    .sa_out_mode(sa_out_mode), .sa_calc_done(sa_calc_done),
    .sa_dout_done(sa_dout_done), .sa_raddr(sa_raddr), .sa_waddr(sa_waddr),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // array model controls and observations
  int m_k = 1, m_rb = 0, m_wb = 0, m_mode = 0, m_clat = 1, m_dlat = 1;
  bit m_hang = 0;
  int phase = 0, cnt = 0, tile = 0, cyc = 0;
  int n_start = 0, n_clear = 0, n_done = 0;
  int start_cyc = 0, done_cyc = 0, ddone_cyc = 0;
  logic done_err = 1'b0;

  initial begin : array_model
    sa_calc_done = 1'b0; sa_dout_done = 1'b0; sa_raddr = '0; sa_waddr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      sa_calc_done = 1'b0;
      sa_dout_done = 1'b0;
      if (rst) begin
        phase = 0; sa_raddr = '0; sa_waddr = '0;
      end else begin
        if (done) begin n_done++; done_cyc = cyc; done_err = err; end
        if (!busy) phase = 0;
        if (phase == 1) chk("mem_raddr", mem_raddr, (m_rb + tile * m_k + sa_raddr) % 8192);
        if (phase == 2) chk("mem_waddr", mem_waddr, (m_wb + tile * N + sa_waddr) % 8192);
        if (sa_start) begin
          tile = n_start; n_start++; start_cyc = cyc;
          chk("k_param", sa_k_param, m_k);
          chk("out_mode", sa_out_mode, m_mode);
          phase = 1; cnt = 0; sa_raddr = '0;
        end else if (sa_clear) begin
          n_clear++; phase = 2; cnt = 0; sa_raddr = '0; sa_waddr = '0;
        end else if (phase == 1) begin
          cnt++;
          sa_raddr = 13'(cnt % (m_k == 0 ? 1 : m_k));
          if (!m_hang && cnt == m_clat) begin sa_calc_done = 1'b1; phase = 0; end
        end else if (phase == 2) begin
          cnt++;
          sa_waddr = 13'(cnt % N);
          if (cnt == m_dlat) begin sa_dout_done = 1'b1; ddone_cyc = cyc; phase = 0; end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic issue(input int k, input int tiles, input int mode, input int rb,
                       input int wb, input int clat, input int dlat, input bit hang);
    m_k = k; m_rb = rb; m_wb = wb; m_mode = mode; m_clat = clat; m_dlat = dlat;
    m_hang = hang; n_start = 0; n_clear = 0; n_done = 0;
    cmd_valid = 1'b1; cmd_k = 8'(k); cmd_tiles = 8'(tiles); cmd_out_mode = mode[0];
    cmd_rbase = 13'(rb); cmd_wbase = 13'(wb);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input int k, input int tiles, input int mode, input int rb,
                         input int wb, input int clat, input int dlat, input bit hang);
    bit illegal;
    bit exp_err;
    int bound;
    illegal = (k == 0) || (tiles == 0);
    exp_err = illegal || hang;
    chk("ready_before", cmd_ready, 1);
    issue(k, tiles, mode, rb, wb, clat, dlat, hang);
    if (illegal) begin
      chk("ill_done_t1", done, 1);
      chk("ill_err_t1", err, 1);
      chk("ill_start_t1", sa_start, 0);
      step();
      chk("ill_ready_t2", cmd_ready, 1);
      chk("ill_done_t2", done, 0);
    end else begin
      chk("start_t1", sa_start, 1);
      chk("busy_t1", busy, 1);
      chk("ready_t1", cmd_ready, 0);
      bound = 0;
      while (n_done == 0 && bound < 4000) begin step(); bound++; end
      if (n_done == 0) chk("done_timeout", 0, 1);
    end
    repeat (3) step();
    chk("done_count", n_done, 1);
    chk("done_err", done_err, exp_err);
    chk("starts", n_start, illegal ? 0 : (hang ? 1 : tiles));
    chk("clears", n_clear, exp_err ? 0 : tiles);
    chk("busy_after", busy, 0);
    if (hang) chk("timeout_lat", done_cyc - start_cyc, TO + 2);
    else if (!illegal) chk("done_lat", done_cyc - ddone_cyc, 2);
  endtask

  initial begin
    int bound;
    rst = 1'b1; cmd_valid = 1'b0; cmd_k = '0; cmd_tiles = '0; cmd_out_mode = 1'b0;
    cmd_rbase = '0; cmd_wbase = '0;
    repeat (3) step();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_start", sa_start, 0);
    chk("rst_kparam", sa_k_param, 0);
    chk("rst_raddr", mem_raddr, 0);
    rst = 1'b0;
    step();

    run_cmd(4, 1, 0, 'h100, 'h200, 4, 8, 0);
    run_cmd(16, 3, 1, 0, 'h40, 16, 8, 0);
    run_cmd(0, 2, 0, 'h10, 'h20, 4, 4, 0);
    run_cmd(5, 0, 1, 'h10, 'h20, 4, 4, 0);
    run_cmd(8, 2, 0, 'h300, 'h400, 5, 5, 1);
    run_cmd(3, 1, 1, 'h55, 'h66, 3, 4, 0);
    run_cmd(8, 1, 0, 'h20, 'h30, TO, 6, 0);
    for (int i = 0; i < 6; i++)
      run_cmd($urandom_range(1, 20), $urandom_range(1, 4), $urandom_range(0, 1),
              $urandom_range(0, 8191), $urandom_range(0, 8191),
              $urandom_range(1, 30), $urandom_range(1, 20), 0);

    // reset during drain of tile 2 of 3, with base wrap on the second tile
    issue(16, 3, 1, 'h1FF8, 0, 20, 10, 0);
    bound = 0;
    while (n_clear < 1 && bound < 500) begin step(); bound++; end
    cmd_valid = 1'b1; cmd_k = 8'd0;
    repeat (3) begin
      step();
      chk("busy_ready", cmd_ready, 0);
      chk("busy_err", err, 0);
    end
    cmd_valid = 1'b0;
    bound = 0;
    while (n_clear < 2 && bound < 500) begin step(); bound++; end
    if (n_clear < 2) chk("tile2_timeout", 0, 1);
    repeat (2) step();
    chk("wrap_raddr", mem_raddr, 'h0008);
    chk("drain_busy", busy, 1);
    rst = 1'b1;
    step();
    chk("mid_ready", cmd_ready, 1);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_err", err, 0);
    chk("mid_clear", sa_clear, 0);
    chk("mid_start", sa_start, 0);
    chk("mid_kparam", sa_k_param, 0);
    chk("mid_mode", sa_out_mode, 0);
    chk("mid_raddr", mem_raddr, 0);
    rst = 1'b0;
    repeat (10) step();
    chk("mid_no_done", n_done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
